// File: rtl/arbiter_fifo2pipeout.sv
// Return-path arbiter: sweeps the selected core output FIFOs in ascending order and
// copies each core's block (payload then zero padding) into the pipe-out FIFO.
// Optional build macro PIPEOUT_CORE_HEADER_EN prepends a header word to every block.
module arbiter_fifo2pipeout #(
   parameter int NUM_CORES = 8,
   parameter int WORD_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_CORES-1:0]        core_select,
   input  logic [9:0]                  num_words,
   input  logic [1:0]                  padding_words,
   output logic                        idle,
   output logic                        done,
   input  logic [NUM_CORES*WORD_W-1:0] data_from_fifo,
   input  logic [NUM_CORES-1:0]        empty_from_fifo,
   output logic [NUM_CORES-1:0]        rd_en_2fifo,
   output logic [WORD_W-1:0]           pipe_out_data,
   output logic                        pipe_out_write,
   input  logic                        pipe_out_full
);

   localparam int AW = $clog2(NUM_CORES + 1);
   localparam int IW = $clog2(NUM_CORES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK_ADDR,
      S_HEADER,
      S_TRANSFER,
      S_PAD,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [9:0]             cnt_q, cnt_d;
   logic [NUM_CORES-1:0]   sel_q, sel_d;
   logic [9:0]             nw_q, nw_d;
   logic [1:0]             pad_q, pad_d;

   logic [IW-1:0]          core_idx;
   logic [9:0]             payload;
   logic [WORD_W-1:0]      head_word;
   logic                   go;

   // addr_q reaches NUM_CORES only in CHECK_ADDR, where the select bit is not consulted
   assign core_idx  = addr_q[IW-1:0];
   assign payload   = ({8'd0, pad_q} >= nw_q) ? 10'd0 : (nw_q - {8'd0, pad_q});
   assign head_word = data_from_fifo[core_idx*WORD_W +: WORD_W];
   assign go        = ~empty_from_fifo[core_idx] & ~pipe_out_full;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      cnt_d          = cnt_q;
      sel_d          = sel_q;
      nw_d           = nw_q;
      pad_d          = pad_q;
      idle           = 1'b0;
      done           = 1'b0;
      rd_en_2fifo    = '0;
      pipe_out_data  = '0;
      pipe_out_write = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle = 1'b1;
            if (start) begin
               sel_d   = core_select;
               nw_d    = num_words;
               pad_d   = padding_words;
               addr_d  = '0;
               state_d = S_CHECK_ADDR;
            end
         end
         S_CHECK_ADDR: begin
            if (addr_q == AW'(NUM_CORES)) begin
               state_d = S_DONE;
            end else if (sel_q[core_idx]) begin
               cnt_d = '0;
`ifdef PIPEOUT_CORE_HEADER_EN
               state_d = S_HEADER;
`else
               state_d = S_TRANSFER;
`endif
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
`ifdef PIPEOUT_CORE_HEADER_EN
         S_HEADER: begin
            pipe_out_data = WORD_W'({8'hA5, 5'd0, addr_q[2:0], 6'd0, nw_q});
            if (!pipe_out_full) begin
               pipe_out_write = 1'b1;
               state_d        = S_TRANSFER;
            end
         end
`endif
         S_TRANSFER: begin
            if (cnt_q >= payload) begin
               state_d = S_PAD;
            end else begin
               pipe_out_data          = head_word;
               pipe_out_write         = go;
               rd_en_2fifo[core_idx]  = go;
               if (go) begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         S_PAD: begin
            if (cnt_q >= nw_q) begin
               addr_d  = addr_q + AW'(1);
               state_d = S_CHECK_ADDR;
            end else if (!pipe_out_full) begin
               pipe_out_write = 1'b1;
               cnt_d          = cnt_q + 10'd1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         nw_q    <= '0;
         pad_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         nw_q    <= nw_d;
         pad_q   <= pad_d;
      end
   end

endmodule

// File: tb/tb_arbiter_fifo2pipeout.sv
// Scoreboard bench for arbiter_fifo2pipeout: core FIFOs are modelled as queues, the
// expected write stream is derived per sweep from the block rules and checked by a monitor.
module tb_arbiter_fifo2pipeout;

   localparam int NC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    core_select = '0;
   logic [9:0]    num_words = '0;
   logic [1:0]    padding_words = '0;
   logic          idle;
   logic          done;
   logic [255:0]  data_from_fifo = '0;
   logic [7:0]    empty_from_fifo = '1;
   logic [7:0]    rd_en_2fifo;
   logic [31:0]   pipe_out_data;
   logic          pipe_out_write;
   logic          pipe_out_full = 1'b0;

   arbiter_fifo2pipeout dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .core_select    (core_select),
      .num_words      (num_words),
      .padding_words  (padding_words),
      .idle           (idle),
      .done           (done),
      .data_from_fifo (data_from_fifo),
      .empty_from_fifo(empty_from_fifo),
      .rd_en_2fifo    (rd_en_2fifo),
      .pipe_out_data  (pipe_out_data),
      .pipe_out_write (pipe_out_write),
      .pipe_out_full  (pipe_out_full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  rd;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fq[NC][$];

   int checks = 0;
   int fails = 0;
   int rd_idx = 0;
   int done_seen = 0;
   int exp_done_total = 0;
   int exp_busy = -1;
   int exp_pops = -1;
   int sweep_id = 0;
   int seen_sweep = 0;
   int busy_run = 0;
   int pop_cnt = 0;
   logic       rst_prev = 1'b1;
   logic [7:0] pend_pop = '0;
   int full_mode = 0;
   int stall_pct = 0;
   logic [7:0] stall_force = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every observed write against the scoreboard and audits each sweep
   always @(negedge clk) begin
      exp_t e;
      int   left;
      pend_pop = rd_en_2fifo;
      if (rst_prev) begin
         chk("reset_idle", 64'(idle), 64'd1);
         chk("reset_done", 64'(done), 64'd0);
         chk("reset_rd_en", 64'(rd_en_2fifo), 64'd0);
         chk("reset_write", 64'(pipe_out_write), 64'd0);
         chk("reset_data", 64'(pipe_out_data), 64'd0);
         rd_idx   = exp_q.size();
         busy_run = 0;
         pop_cnt  = 0;
      end else begin
         if (pipe_out_write) begin
            if (pipe_out_full) chk("write_while_full", 64'd1, 64'd0);
            if (rd_idx >= exp_q.size()) begin
               chk("unexpected_write", 64'(pipe_out_data), 64'hFFFFFFFF_FFFFFFFF);
            end else begin
               e = exp_q[rd_idx];
               rd_idx++;
               chk("write_data", 64'(pipe_out_data), 64'(e.data));
               chk("write_rd_en", 64'(rd_en_2fifo), 64'(e.rd));
            end
         end else begin
            chk("pop_without_write", 64'(rd_en_2fifo), 64'd0);
         end
         if ((rd_en_2fifo & empty_from_fifo) != 8'd0)
            chk("pop_from_empty", 64'(rd_en_2fifo & empty_from_fifo), 64'd0);
         if (rd_en_2fifo != 8'd0) pop_cnt++;
         if (done) begin
            done_seen++;
            if (exp_busy >= 0) chk("busy_cycles", 64'(busy_run), 64'(exp_busy));
            busy_run = 0;
         end else if (!idle) begin
            busy_run++;
         end
      end
      if (sweep_id != seen_sweep) begin
         seen_sweep = sweep_id;
         left = 0;
         for (int c = 0; c < NC; c++) left += fq[c].size();
         chk("all_writes_seen", 64'(rd_idx), 64'(exp_q.size()));
         chk("done_count", 64'(done_seen), 64'(exp_done_total));
         if (exp_pops >= 0) chk("pop_count", 64'(pop_cnt), 64'(exp_pops));
         chk("fifos_drained", 64'(left), 64'd0);
         chk("idle_after", 64'(idle), 64'd1);
         pop_cnt = 0;
      end
      rst_prev = rst;
   end

   task automatic driveFifos();
      logic [7:0] stall;
      for (int c = 0; c < NC; c++) begin
         stall[c] = stall_force[c] | (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
         empty_from_fifo[c] = stall[c] | (fq[c].size() == 0);
         data_from_fifo[c*32 +: 32] = (fq[c].size() > 0) ? fq[c][0] : (32'hDEAD0000 | 32'(c));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
         if (pend_pop[c] && fq[c].size() > 0) void'(fq[c].pop_front());
      case (full_mode)
         1: pipe_out_full = ~pipe_out_full;
         2: pipe_out_full = ($urandom_range(0, 3) == 0);
         default: pipe_out_full = 1'b0;
      endcase
      driveFifos();
   endtask

   // Reference model: each selected core yields P payload pops then nw-P zero words
   task automatic applyStimulus(input logic [7:0] sel, input int nw, input int pad,
                                input bit use_rand, input int busy);
      int p, pops;
      logic [31:0] w;
      pops = 0;
      p = (pad >= nw) ? 0 : nw - pad;
      for (int c = 0; c < NC; c++) begin
         if (sel[c]) begin
`ifdef PIPEOUT_CORE_HEADER_EN
            exp_q.push_back('{{8'hA5, 5'd0, 3'(c), 6'd0, 10'(nw)}, 8'd0});
`endif
            for (int k = 0; k < p; k++) begin
               w = use_rand ? $urandom : (32'(c) << 8) | 32'(k + 1);
               fq[c].push_back(w);
               exp_q.push_back('{w, 8'(1 << c)});
               pops++;
            end
            for (int k = p; k < nw; k++) exp_q.push_back('{32'd0, 8'd0});
         end
      end
      exp_pops = pops;
      exp_busy = busy;
      exp_done_total++;
      core_select   = sel;
      num_words     = 10'(nw);
      padding_words = 2'(pad);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input int limit);
      for (int i = 0; i < limit && done_seen < exp_done_total; i++) tick();
      tick();
      tick();
   endtask

   task automatic checkOutput();
      sweep_id++;
      tick();
      tick();
   endtask

   task automatic waitWrites(input int target, input int limit);
      for (int i = 0; i < limit && rd_idx < target; i++) tick();
   endtask

   initial begin
      int base;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      $display("[TB] basic drain");
      applyStimulus(8'h01, 4, 0, 1'b0, -1);
      waitDone(500);
      checkOutput();

      $display("[TB] padding and ordering");
      applyStimulus(8'h81, 3, 1, 1'b0, -1);
      waitDone(500);
      checkOutput();

      $display("[TB] backpressure toggle");
      full_mode = 1;
      applyStimulus(8'h01, 4, 0, 1'b1, -1);
      waitDone(500);
      full_mode = 0;
      checkOutput();

      $display("[TB] underflow stall");
      base = exp_q.size();
      applyStimulus(8'h01, 6, 0, 1'b1, -1);
      waitWrites(base + 2, 200);
      stall_force = 8'h01;
      repeat (10) tick();
      stall_force = 8'h00;
      waitDone(500);
      checkOutput();

      $display("[TB] empty select");
      applyStimulus(8'h00, 5, 0, 1'b1, 9);
      waitDone(500);
      checkOutput();

      $display("[TB] zero words");
      applyStimulus(8'hFF, 0, 0, 1'b1, -1);
      waitDone(500);
      checkOutput();

      $display("[TB] padding exceeds words");
      applyStimulus(8'h02, 2, 3, 1'b1, -1);
      waitDone(500);
      checkOutput();

      $display("[TB] start while busy");
      applyStimulus(8'h03, 5, 1, 1'b1, -1);
      repeat (3) tick();
      core_select = 8'hFF;
      num_words   = 10'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      waitDone(500);
      checkOutput();

      $display("[TB] reset abort");
      base = exp_q.size();
      applyStimulus(8'h01, 8, 0, 1'b1, -1);
      exp_done_total--;
      exp_pops = -1;
      waitWrites(base + 2, 200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < NC; c++) fq[c].delete();
      driveFifos();
      repeat (5) tick();
      checkOutput();
      applyStimulus(8'h01, 4, 0, 1'b0, -1);
      waitDone(500);
      checkOutput();

      $display("[TB] randomized sweeps");
      full_mode = 2;
      stall_pct = 20;
      for (int n = 0; n < 25; n++) begin
         applyStimulus(8'($urandom), $urandom_range(0, 12), $urandom_range(0, 3), 1'b1, -1);
         waitDone(3000);
         checkOutput();
      end
      full_mode = 0;
      stall_pct = 0;
      repeat (3) tick();

      $display("[TB] %0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
